// File: rtl/sprite_compositor.sv
// N-channel sprite compositor: fetches per-channel bitmap bits, picks colour by fixed
// priority (channel 0 highest) and accumulates player (channel 0) overlaps per frame.
module sprite_compositor #(
  parameter int N_SPR  = 4,
  parameter int SPR_W  = 32,
  parameter int SPR_H  = 48,
  parameter int COL_AW = 5,
  parameter int ROW_AW = 6,
  parameter int CW     = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [9:0]              hcount,
  input  logic [9:0]              vcount,
  input  logic                    active,
  input  logic                    frame_start,
  input  logic [N_SPR-1:0]        spr_en,
  input  logic [N_SPR*10-1:0]     spr_x,
  input  logic [N_SPR*10-1:0]     spr_y,
  input  logic [N_SPR*CW-1:0]     spr_color,
  output logic [N_SPR*ROW_AW-1:0] rom_row,
  output logic [N_SPR*COL_AW-1:0] rom_col,
  input  logic [N_SPR-1:0]        rom_bit,
  input  logic                    debug_nocollide,
  input  logic                    collide_clr,
  output logic [CW-1:0]           pix_color,
  output logic                    pix_valid,
  output logic [N_SPR-1:0]        hit_mask,
  output logic                    collide
);

  logic [N_SPR-1:0]        inside_c;
  logic [N_SPR*COL_AW-1:0] col_c;
  logic [N_SPR*ROW_AW-1:0] row_c;
  logic [N_SPR-1:0]        inside_p1;
  logic                    vld_p1;
  logic [N_SPR*CW-1:0]     color_p1;
  logic [N_SPR-1:0]        on_p1;
  logic [N_SPR-1:0]        hit_p1;
  logic [N_SPR-1:0]        acc;
  logic [N_SPR-1:0]        latched;

  function automatic logic [CW-1:0] pick_color(input logic [N_SPR-1:0] on,
                                                input logic [N_SPR*CW-1:0] colors);
    logic [CW-1:0] c;
    c = '0;
    for (int i = N_SPR - 1; i >= 0; i--)
      if (on[i]) c = colors[i*CW +: CW];
    return c;
  endfunction

  // Stage 1: window test on 11-bit sums so sprites near 1023 clip instead of wrapping
  always_comb begin
    inside_c = '0;
    col_c    = '0;
    row_c    = '0;
    for (int i = 0; i < N_SPR; i++) begin
      inside_c[i] = spr_en[i] & active
        & ({1'b0, hcount} >= {1'b0, spr_x[10*i +: 10]})
        & ({1'b0, hcount} <  ({1'b0, spr_x[10*i +: 10]} + 11'(SPR_W)))
        & ({1'b0, vcount} >= {1'b0, spr_y[10*i +: 10]})
        & ({1'b0, vcount} <  ({1'b0, spr_y[10*i +: 10]} + 11'(SPR_H)));
      if (inside_c[i]) begin
        col_c[i*COL_AW +: COL_AW] = COL_AW'(hcount - spr_x[10*i +: 10]);
        row_c[i*ROW_AW +: ROW_AW] = ROW_AW'(vcount - spr_y[10*i +: 10]);
      end
    end
  end

  // Stage 2: ROM bits line up with the stage-1 registers
  assign on_p1   = inside_p1 & rom_bit;
  assign hit_p1  = on_p1[0] ? {on_p1[N_SPR-1:1], 1'b0} : '0;
  assign latched = acc | hit_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inside_p1 <= '0;
      vld_p1    <= 1'b0;
      color_p1  <= '0;
      rom_col   <= '0;
      rom_row   <= '0;
      pix_color <= '0;
      pix_valid <= 1'b0;
      acc       <= '0;
      hit_mask  <= '0;
      collide   <= 1'b0;
    end else begin
      inside_p1 <= inside_c;
      vld_p1    <= active;
      color_p1  <= spr_color;
      rom_col   <= col_c;
      rom_row   <= row_c;
      pix_color <= pick_color(on_p1, color_p1);
      pix_valid <= vld_p1;
      if (frame_start) begin
        hit_mask <= latched;
        acc      <= '0;
      end else begin
        acc <= latched;
      end
      // Set beats clear; the debug override beats both
      if (debug_nocollide)
        collide <= 1'b0;
      else if (frame_start && (latched != '0))
        collide <= 1'b1;
      else if (collide_clr)
        collide <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenarios plus randomized pixels against a
// behavioural per-pixel model and a ROM model driven from the DUT's addresses.
module tb_sprite_compositor;
  localparam int N = 4, CW = 4, COL_AW = 5, ROW_AW = 6, SPR_W = 32, SPR_H = 48;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [9:0]        hcount, vcount;
  logic              active, frame_start;
  logic [N-1:0]      spr_en;
  logic [N*10-1:0]   spr_x, spr_y;
  logic [N*CW-1:0]   spr_color;
  logic [N*ROW_AW-1:0] rom_row;
  logic [N*COL_AW-1:0] rom_col;
  logic [N-1:0]      rom_bit;
  logic              debug_nocollide, collide_clr;
  logic [CW-1:0]     pix_color;
  logic              pix_valid;
  logic [N-1:0]      hit_mask;
  logic              collide;

  int total = 0, bad = 0;
  bit solid = 1'b1;
  bit mon_en = 1'b0;
  int seen [0:1023];

  sprite_compositor dut (
    .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount), .active(active),
    .frame_start(frame_start), .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y),
    .spr_color(spr_color), .rom_row(rom_row), .rom_col(rom_col), .rom_bit(rom_bit),
    .debug_nocollide(debug_nocollide), .collide_clr(collide_clr), .pix_color(pix_color),
    .pix_valid(pix_valid), .hit_mask(hit_mask), .collide(collide)
  );

  always #20 clk = ~clk;

  function automatic logic bitmap(input bit sld, input int i, input int r, input int c);
    if (sld) return 1'b1;
    return ((r * 3 + c * 5 + i) % 4) != 0;
  endfunction

  always_comb begin
    rom_bit = '0;
    for (int i = 0; i < N; i++)
      rom_bit[i] = bitmap(solid, i, int'(rom_row[i*ROW_AW +: ROW_AW]), int'(rom_col[i*COL_AW +: COL_AW]));
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: what each output must be after every clock edge
  int m_pix = 0, m_valid = 0, m_mask = 0, m_collide = 0, m_acc = 0;
  int r_pix = 0, r_act = 0, r_hit = 0;
  int m_col [N];
  int m_row [N];
  int hq1 = -1, hq2 = -1;

  initial begin
    int lat, on, x, y, h, v;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_pix = 0; m_valid = 0; m_mask = 0; m_collide = 0; m_acc = 0;
        r_pix = 0; r_act = 0; r_hit = 0; hq1 = -1; hq2 = -1;
        for (int i = 0; i < N; i++) begin m_col[i] = 0; m_row[i] = 0; end
      end else begin
        lat = m_acc | r_hit;
        if (debug_nocollide) m_collide = 0;
        else if (frame_start && lat != 0) m_collide = 1;
        else if (collide_clr) m_collide = 0;
        if (frame_start) begin m_mask = lat; m_acc = 0; end
        else m_acc = lat;
        m_pix = r_pix;
        m_valid = r_act;
        hq2 = hq1;
        hq1 = int'(hcount);
        h = int'(hcount);
        v = int'(vcount);
        on = 0;
        for (int i = 0; i < N; i++) begin
          x = int'(spr_x[i*10 +: 10]);
          y = int'(spr_y[i*10 +: 10]);
          m_col[i] = 0;
          m_row[i] = 0;
          if (spr_en[i] && active && h >= x && h < x + SPR_W && v >= y && v < y + SPR_H) begin
            m_col[i] = h - x;
            m_row[i] = v - y;
            if (bitmap(solid, i, v - y, h - x)) on |= (1 << i);
          end
        end
        r_pix = 0;
        for (int i = N - 1; i >= 0; i--)
          if (on[i]) r_pix = int'(spr_color[i*CW +: CW]);
        r_hit = on[0] ? (on & (((1 << N) - 1) & ~1)) : 0;
        r_act = int'(active);
      end
    end
  end

  // Compare process, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && mon_en) begin
        chk("pix_color", int'(pix_color), m_pix);
        chk("pix_valid", int'(pix_valid), m_valid);
        chk("hit_mask", int'(hit_mask), m_mask);
        chk("collide", int'(collide), m_collide);
        for (int i = 0; i < N; i++) begin
          chk("rom_col", int'(rom_col[i*COL_AW +: COL_AW]), m_col[i]);
          chk("rom_row", int'(rom_row[i*ROW_AW +: ROW_AW]), m_row[i]);
        end
        if (pix_valid && hq2 >= 0) seen[hq2] = int'(pix_color);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_spr(input int i, input bit en, input int x, input int y, input int c);
    spr_en[i] = en;
    spr_x[i*10 +: 10] = 10'(x);
    spr_y[i*10 +: 10] = 10'(y);
    spr_color[i*CW +: CW] = CW'(c);
  endtask

  task automatic clear_seen();
    for (int i = 0; i < 1024; i++) seen[i] = 99;
  endtask

  task automatic scan(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) begin
      hcount = 10'(h);
      vcount = 10'(v);
      active = (h < 640) && (v < 480);
      step();
    end
    active = 1'b0;
    step();
    step();
  endtask

  task automatic pulse_fs(input bit clr);
    frame_start = 1'b1;
    collide_clr = clr;
    step();
    frame_start = 1'b0;
    collide_clr = 1'b0;
  endtask

  initial begin
    int x, y;
    reset_n = 1'b0; hcount = '0; vcount = '0; active = 1'b0; frame_start = 1'b0;
    spr_en = '0; spr_x = '0; spr_y = '0; spr_color = '0;
    debug_nocollide = 1'b0; collide_clr = 1'b0;
    clear_seen();
    repeat (3) step();
    chk("rst_pix_color", int'(pix_color), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_hit_mask", int'(hit_mask), 0);
    chk("rst_collide", int'(collide), 0);
    chk("rst_rom_col", int'(rom_col), 0);
    reset_n = 1'b1;
    step();
    mon_en = 1'b1;

    // Single sprite, latency and right-edge cut-off
    set_spr(1, 1'b1, 100, 100, 'hA);
    clear_seen();
    scan(100, 95, 140);
    chk("ch1_before", seen[99], 0);
    chk("ch1_first", seen[100], 'hA);
    chk("ch1_last", seen[131], 'hA);
    chk("ch1_after", seen[132], 0);
    pulse_fs(1'b0);
    chk("ch1_no_collide", int'(collide), 0);

    // Player over channel 2: priority and collision
    set_spr(1, 1'b0, 0, 0, 0);
    set_spr(0, 1'b1, 200, 200, 'hF);
    set_spr(2, 1'b1, 200, 200, 'h5);
    clear_seen();
    scan(200, 195, 240);
    chk("prio_color", seen[200], 'hF);
    pulse_fs(1'b0);
    chk("prio_hit_mask", int'(hit_mask), 'b0100);
    chk("prio_collide", int'(collide), 1);

    // Right-edge clipping, no wrap onto the next line
    set_spr(0, 1'b0, 0, 0, 0);
    set_spr(2, 1'b0, 0, 0, 0);
    set_spr(3, 1'b1, 620, 0, 'h9);
    clear_seen();
    scan(10, 600, 639);
    scan(11, 0, 15);
    chk("edge_before", seen[619], 0);
    chk("edge_first", seen[620], 'h9);
    chk("edge_last", seen[639], 'h9);
    chk("edge_nowrap0", seen[0], 0);
    chk("edge_nowrap11", seen[11], 0);

    // Clear alone, then clear coinciding with a set
    set_spr(3, 1'b0, 0, 0, 0);
    pulse_fs(1'b1);
    chk("clr_alone", int'(collide), 0);
    set_spr(0, 1'b1, 300, 300, 'hC);
    set_spr(1, 1'b1, 310, 300, 'h3);
    scan(300, 295, 345);
    pulse_fs(1'b1);
    chk("set_wins", int'(collide), 1);
    chk("set_wins_mask", int'(hit_mask), 'b0010);

    // Debug override keeps collide low while hit_mask still updates
    debug_nocollide = 1'b1;
    scan(301, 295, 345);
    pulse_fs(1'b0);
    chk("dbg_collide", int'(collide), 0);
    chk("dbg_mask", int'(hit_mask), 'b0010);
    debug_nocollide = 1'b0;

    // Disabled channel neither draws nor collides
    set_spr(1, 1'b0, 310, 300, 'h3);
    clear_seen();
    scan(302, 295, 345);
    chk("dis_ch0_draws", seen[305], 'hC);
    chk("dis_no_draw", seen[335], 0);
    pulse_fs(1'b0);
    chk("dis_mask", int'(hit_mask), 0);

    // Asynchronous reset mid-frame with collide set and accumulator loaded
    set_spr(1, 1'b1, 310, 300, 'h3);
    scan(303, 295, 345);
    pulse_fs(1'b0);
    chk("pre_rst_collide", int'(collide), 1);
    hcount = 10'd312; vcount = 10'd304; active = 1'b1;
    step();
    step();
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_collide", int'(collide), 0);
    chk("arst_hit_mask", int'(hit_mask), 0);
    chk("arst_pix_color", int'(pix_color), 0);
    active = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
    pulse_fs(1'b0);
    chk("post_rst_mask", int'(hit_mask), 0);

    // Randomized traffic, including mid-frame moves and sprites near coordinate 1023
    for (int seg = 0; seg < 40; seg++) begin
      active = 1'b0;
      frame_start = 1'b0;
      step();
      step();
      solid = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        x = ($urandom_range(0, 9) == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 140));
        y = int'($urandom_range(0, 100));
        set_spr(i, $urandom_range(0, 3) != 0, x, y, int'($urandom_range(0, 15)));
      end
      for (int c = 0; c < 80; c++) begin
        hcount = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 180));
        vcount = 10'($urandom_range(0, 140));
        active = (hcount < 10'd640) && (vcount < 10'd480) && ($urandom_range(0, 7) != 0);
        frame_start = ($urandom_range(0, 29) == 0);
        collide_clr = ($urandom_range(0, 29) == 0);
        debug_nocollide = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 39) == 0)
          set_spr(int'($urandom_range(0, N - 1)), 1'b1, int'($urandom_range(0, 140)),
                  int'($urandom_range(0, 100)), int'($urandom_range(0, 15)));
        step();
      end
      collide_clr = 1'b0;
      debug_nocollide = 1'b0;
    end
    active = 1'b0;
    frame_start = 1'b0;
    step();
    step();
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
